// File: rtl/game_ctrl_pkg.sv
// Shared definitions for the game sequencer and the pixel generator.
package game_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_TITLE = 2'b00,
    ST_PLAY  = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } game_state_t;

  localparam int GRID_W_DEF = 16;
  localparam int GRID_H_DEF = 12;
  localparam int CELL_PX    = 40;

  // Fibonacci LFSR, taps 8,6,5,4, shifting towards the MSB
  function automatic logic [7:0] lfsr8_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

endpackage

// File: rtl/game_ctrl_lfsr8.sv
// Free-running 8-bit pseudo-random source used for target placement.
module lfsr8
  import game_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       dreset,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  // Step every clock; seed must be nonzero or the sequence locks up
  always_ff @(posedge clk) begin
    if (!dreset) q <= seed;
    else         q <= lfsr8_next(q);
  end

endmodule

// File: rtl/game_ctrl.sv
// Game-state sequencer: TITLE/PLAY/PAUSE/OVER, player movement, scoring, frame timer.
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_TITLE | idle title screen, waiting for enter
// ST_PLAY  | game running, frame updates on refr_tick
// ST_PAUSE | game frozen, enter resumes
// ST_OVER  | timer expired, outputs held until enter
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int         GRID_W      = GRID_W_DEF,
  parameter int         GRID_H      = GRID_H_DEF,
  parameter int         XW          = 4,
  parameter int         YW          = 4,
  parameter int         MOVE_DIV    = 8,
  parameter int         GAME_FRAMES = 1800,
  parameter int         TW          = 11,
  parameter int         SCORE_W     = 8,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic               clk,
  input  logic               dreset,
  input  logic               refr_tick,
  input  logic               key_left,
  input  logic               key_right,
  input  logic               key_up,
  input  logic               key_down,
  input  logic               key_enter,
  input  logic               key_reset,
  output logic [1:0]         state,
  output logic [XW-1:0]      player_x,
  output logic [YW-1:0]      player_y,
  output logic [XW-1:0]      target_x,
  output logic [YW-1:0]      target_y,
  output logic [SCORE_W-1:0] score,
  output logic [TW-1:0]      time_left,
  output logic               hit_tick
);

  localparam int            CW     = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [XW-1:0] X_HOME = XW'(GRID_W / 2);
  localparam logic [YW-1:0] Y_HOME = YW'(GRID_H / 2);
  localparam logic [XW-1:0] X_MAX  = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX  = YW'(GRID_H - 1);
  localparam logic [TW-1:0] T_FULL = TW'(GAME_FRAMES);
  localparam logic [CW-1:0] C_LOAD = CW'(MOVE_DIV - 1);

  game_state_t        state_q, state_d;
  logic [XW-1:0]      px_q, px_d, tx_q, tx_d, step_x;
  logic [YW-1:0]      py_q, py_d, ty_q, ty_d, step_y;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [TW-1:0]      time_q, time_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               hit_q, hit_d;
  logic               prev_enter, prev_reset;
  logic [7:0]         lfsr_q;
  logic               enter_rise, reset_rise, dir_held;

  lfsr8 u_lfsr (
    .clk    (clk),
    .dreset (dreset),
    .seed   (LFSR_SEED),
    .q      (lfsr_q)
  );

  assign enter_rise = key_enter & ~prev_enter;
  assign reset_rise = key_reset & ~prev_reset;
  assign dir_held   = key_left | key_right | key_up | key_down;

  assign state     = state_q;
  assign player_x  = px_q;
  assign player_y  = py_q;
  assign target_x  = tx_q;
  assign target_y  = ty_q;
  assign score     = score_q;
  assign time_left = time_q;
  assign hit_tick  = hit_q;

  // Fold LFSR nibbles into the grid and nudge right if the target lands on the player
  function automatic logic [XW+YW-1:0] retarget(input logic [7:0]    l,
                                                input logic [XW-1:0] px,
                                                input logic [YW-1:0] py);
    int tx;
    int ty;
    tx = int'(l[3:0]);
    if (tx >= GRID_W) tx = tx - GRID_W;
    ty = int'(l[7:4]);
    if (ty >= GRID_H) ty = ty - GRID_H;
    if (XW'(tx) == px && YW'(ty) == py) tx = (tx + 1 == GRID_W) ? 0 : tx + 1;
    return {YW'(ty), XW'(tx)};
  endfunction

  // Next state and next values of every game register
  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    score_d = score_q;
    time_d  = time_q;
    cnt_d   = cnt_q;
    hit_d   = 1'b0;
    step_x  = px_q;
    step_y  = py_q;

    if (key_left) begin
      if (px_q != '0) step_x = px_q - XW'(1);
    end else if (key_right) begin
      if (px_q != X_MAX) step_x = px_q + XW'(1);
    end else if (key_up) begin
      if (py_q != '0) step_y = py_q - YW'(1);
    end else if (key_down) begin
      if (py_q != Y_MAX) step_y = py_q + YW'(1);
    end

    if (reset_rise) begin
      state_d = ST_TITLE;
      px_d    = X_HOME;
      py_d    = Y_HOME;
      score_d = '0;
      time_d  = T_FULL;
    end else begin
      case (state_q)
        ST_TITLE: begin
          if (enter_rise) begin
            state_d      = ST_PLAY;
            px_d         = X_HOME;
            py_d         = Y_HOME;
            score_d      = '0;
            time_d       = T_FULL;
            {ty_d, tx_d} = retarget(lfsr_q, X_HOME, Y_HOME);
          end
        end
        ST_PLAY: begin
          if (enter_rise) begin
            state_d = ST_PAUSE;
          end else if (refr_tick) begin
            if (!dir_held) begin
              cnt_d = '0;
            end else if (cnt_q == '0) begin
              px_d  = step_x;
              py_d  = step_y;
              cnt_d = C_LOAD;
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
            if (px_d == tx_q && py_d == ty_q) begin
              if (score_q != '1) score_d = score_q + SCORE_W'(1);
              hit_d        = 1'b1;
              {ty_d, tx_d} = retarget(lfsr_q, px_d, py_d);
            end
            if (time_q != '0) time_d = time_q - TW'(1);
            if (time_q == TW'(1)) state_d = ST_OVER;
          end
        end
        ST_PAUSE: begin
          if (enter_rise) state_d = ST_PLAY;
        end
        ST_OVER: begin
          if (enter_rise) state_d = ST_TITLE;
        end
        default: state_d = ST_TITLE;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!dreset) state_q <= ST_TITLE;
    else         state_q <= state_d;
  end

  // Position, target, score, timer, repeat counter and key history registers
  always_ff @(posedge clk) begin
    if (!dreset) begin
      px_q       <= X_HOME;
      py_q       <= Y_HOME;
      tx_q       <= '0;
      ty_q       <= '0;
      score_q    <= '0;
      time_q     <= T_FULL;
      cnt_q      <= '0;
      hit_q      <= 1'b0;
      prev_enter <= 1'b0;
      prev_reset <= 1'b0;
    end else begin
      px_q       <= px_d;
      py_q       <= py_d;
      tx_q       <= tx_d;
      ty_q       <= ty_d;
      score_q    <= score_d;
      time_q     <= time_d;
      cnt_q      <= cnt_d;
      hit_q      <= hit_d;
      prev_enter <= key_enter;
      prev_reset <= key_reset;
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: four instances share one stimulus stream.
//  dut0: defaults (seed A5)         dut1: seed 69 -> first target (9,6)
//  dut2: 3-frame game (seed A5)     dut3: 1-frame game, seed 69
module tb_game_ctrl;

  localparam int K_L = 1, K_R = 2, K_U = 4, K_D = 8, K_E = 16, K_X = 32;

  logic clk = 1'b0;
  logic dreset, refr_tick;
  logic key_left, key_right, key_up, key_down, key_enter, key_reset;

  logic [1:0]  st_o  [4];
  logic [3:0]  px_o  [4];
  logic [3:0]  py_o  [4];
  logic [3:0]  tx_o  [4];
  logic [3:0]  ty_o  [4];
  logic [7:0]  sc_o  [4];
  logic [10:0] tl_o  [4];
  logic        hit_o [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    game_ctrl #(
      .LFSR_SEED   ((g == 1 || g == 3) ? 8'h69 : 8'hA5),
      .GAME_FRAMES ((g == 2) ? 3 : ((g == 3) ? 1 : 1800))
    ) dut (
      .clk       (clk),
      .dreset    (dreset),
      .refr_tick (refr_tick),
      .key_left  (key_left),
      .key_right (key_right),
      .key_up    (key_up),
      .key_down  (key_down),
      .key_enter (key_enter),
      .key_reset (key_reset),
      .state     (st_o[g]),
      .player_x  (px_o[g]),
      .player_y  (py_o[g]),
      .target_x  (tx_o[g]),
      .target_y  (ty_o[g]),
      .score     (sc_o[g]),
      .time_left (tl_o[g]),
      .hit_tick  (hit_o[g])
    );
  end

  // Reference LFSRs for the two seeds in use
  function automatic logic [7:0] lstep(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  logic [7:0] m_a5, m_69;
  always @(posedge clk) begin
    if (!dreset) begin
      m_a5 <= 8'hA5;
      m_69 <= 8'h69;
    end else begin
      m_a5 <= lstep(m_a5);
      m_69 <= lstep(m_69);
    end
  end

  // Expected target from an LFSR value and the player position: returns {ty,tx}
  function automatic logic [7:0] rtg(input logic [7:0] l, input int px, input int py);
    int tx;
    int ty;
    tx = int'(l[3:0]);
    if (tx >= 16) tx -= 16;
    ty = int'(l[7:4]);
    if (ty >= 12) ty -= 12;
    if (tx == px && ty == py) tx = (tx + 1) % 16;
    return {ty[3:0], tx[3:0]};
  endfunction

  typedef struct {
    int inst;
    int st; int px; int py; int sc; int tl; int hit;
    bit chk_t; int tx; int ty;
  } exp_t;

  typedef struct { int keys; bit rt; int st; int px; int py; int tl; } vec_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string name, input int inst, input int act, input int want);
    n_total++;
    if (act == want) n_pass++;
    else $display("FAIL %s dut%0d: got %0d, expected %0d", name, inst, act, want);
  endtask

  task automatic expect_out(input int inst, input int st, input int px, input int py,
                            input int sc, input int tl, input int hit,
                            input bit chk_t = 1'b0, input int tx = 0, input int ty = 0);
    exp_t e;
    e.inst = inst; e.st = st; e.px = px; e.py = py; e.sc = sc; e.tl = tl; e.hit = hit;
    e.chk_t = chk_t; e.tx = tx; e.ty = ty;
    sb.push_back(e);
  endtask

  task automatic drive(input int keys, input bit rt, input bit rb = 1'b1);
    @(negedge clk);
    dreset    = rb;
    refr_tick = rt;
    key_left  = keys[0];
    key_right = keys[1];
    key_up    = keys[2];
    key_down  = keys[3];
    key_enter = keys[4];
    key_reset = keys[5];
  endtask

  task automatic settle();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk("state",     e.inst, int'(st_o[e.inst]),  e.st);
      chk("player_x",  e.inst, int'(px_o[e.inst]),  e.px);
      chk("player_y",  e.inst, int'(py_o[e.inst]),  e.py);
      chk("score",     e.inst, int'(sc_o[e.inst]),  e.sc);
      chk("time_left", e.inst, int'(tl_o[e.inst]),  e.tl);
      chk("hit_tick",  e.inst, int'(hit_o[e.inst]), e.hit);
      if (e.chk_t) begin
        chk("target_x", e.inst, int'(tx_o[e.inst]), e.tx);
        chk("target_y", e.inst, int'(ty_o[e.inst]), e.ty);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    vec_t       tbl [18];
    logic [7:0] t;

    // Pause / resume / coincident-enter / reset-key sequence for dut0
    tbl[0]  = '{K_E,       1'b0, 2, 14, 6, 1730};
    tbl[1]  = '{0,         1'b0, 2, 14, 6, 1730};
    tbl[2]  = '{K_L,       1'b1, 2, 14, 6, 1730};
    tbl[3]  = '{K_L,       1'b0, 2, 14, 6, 1730};
    tbl[4]  = '{K_L,       1'b1, 2, 14, 6, 1730};
    tbl[5]  = '{K_L,       1'b1, 2, 14, 6, 1730};
    tbl[6]  = '{K_L,       1'b1, 2, 14, 6, 1730};
    tbl[7]  = '{K_L,       1'b1, 2, 14, 6, 1730};
    tbl[8]  = '{0,         1'b0, 2, 14, 6, 1730};
    tbl[9]  = '{K_E,       1'b0, 1, 14, 6, 1730};
    tbl[10] = '{0,         1'b1, 1, 14, 6, 1729};
    tbl[11] = '{K_E,       1'b1, 2, 14, 6, 1729};
    tbl[12] = '{0,         1'b1, 2, 14, 6, 1729};
    tbl[13] = '{K_E,       1'b0, 1, 14, 6, 1729};
    tbl[14] = '{K_E | K_L, 1'b1, 1, 13, 6, 1728};
    tbl[15] = '{K_X,       1'b0, 0,  8, 6, 1800};
    tbl[16] = '{K_X | K_R, 1'b1, 0,  8, 6, 1800};
    tbl[17] = '{0,         1'b1, 0,  8, 6, 1800};

    dreset = 1'b0; refr_tick = 1'b0;
    key_left = 1'b0; key_right = 1'b0; key_up = 1'b0; key_down = 1'b0;
    key_enter = 1'b0; key_reset = 1'b0;

    // ---- dut0: reset, start, held-key repeat and clamp ----
    for (int i = 0; i < 2; i++) begin
      drive(0, 1'b0, 1'b0);
      expect_out(0, 0, 8, 6, 0, 1800, 0, 1'b1, 0, 0);
      settle();
    end
    drive(K_E, 1'b0);
    expect_out(0, 1, 8, 6, 0, 1800, 0, 1'b1, 5, 10);
    settle();
    drive(0, 1'b0);
    expect_out(0, 1, 8, 6, 0, 1800, 0, 1'b1, 5, 10);
    settle();
    for (int k = 1; k <= 64; k++) begin
      int x;
      x = 8 + (k - 1) / 8 + 1;
      if (x > 15) x = 15;
      drive(K_R, 1'b1);
      expect_out(0, 1, x, 6, 0, 1800 - k, 0, 1'b1, 5, 10);
      settle();
      drive(K_R, 1'b0);
      settle();
    end
    drive(0, 1'b1);                   expect_out(0, 1, 15, 6, 0, 1735, 0); settle();
    drive(K_L | K_R | K_U, 1'b1);     expect_out(0, 1, 14, 6, 0, 1734, 0); settle();
    drive(0, 1'b1);                   expect_out(0, 1, 14, 6, 0, 1733, 0); settle();
    drive(K_U | K_D, 1'b1);           expect_out(0, 1, 14, 5, 0, 1732, 0); settle();
    drive(0, 1'b1);                   expect_out(0, 1, 14, 5, 0, 1731, 0); settle();
    drive(K_D, 1'b1);                 expect_out(0, 1, 14, 6, 0, 1730, 0); settle();

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].keys, tbl[i].rt);
      expect_out(0, tbl[i].st, tbl[i].px, tbl[i].py, 0, tbl[i].tl, 0, 1'b1, 5, 10);
      settle();
    end

    // ---- dut1/dut3: forced target (9,6), capture, capture on the final frame ----
    for (int i = 0; i < 2; i++) begin
      drive(K_E, 1'b0, 1'b0);
      expect_out(1, 0, 8, 6, 0, 1800, 0, 1'b1, 0, 0);
      expect_out(3, 0, 8, 6, 0, 1, 0);
      settle();
    end
    drive(K_E, 1'b0);
    expect_out(1, 1, 8, 6, 0, 1800, 0, 1'b1, 9, 6);
    expect_out(3, 1, 8, 6, 0, 1, 0, 1'b1, 9, 6);
    settle();
    drive(0, 1'b0);
    expect_out(1, 1, 8, 6, 0, 1800, 0);
    expect_out(3, 1, 8, 6, 0, 1, 0);
    settle();
    drive(K_R, 1'b1);
    t = rtg(m_69, 9, 6);
    expect_out(1, 1, 9, 6, 1, 1799, 1, 1'b1, int'(t[3:0]), int'(t[7:4]));
    expect_out(3, 3, 9, 6, 1, 0, 1, 1'b1, int'(t[3:0]), int'(t[7:4]));
    settle();
    chk("retarget_moved", 1, int'(tx_o[1] == 4'd9 && ty_o[1] == 4'd6), 0);
    drive(K_R, 1'b0);
    expect_out(1, 1, 9, 6, 1, 1799, 0);
    expect_out(3, 3, 9, 6, 1, 0, 0);
    settle();
    drive(K_R, 1'b1);
    expect_out(1, 1, 9, 6, 1, 1798, 0);
    expect_out(3, 3, 9, 6, 1, 0, 0);
    settle();

    // ---- dut2: 3-frame game, OVER, restart, reset key during PAUSE ----
    for (int i = 0; i < 2; i++) begin
      drive(0, 1'b0, 1'b0);
      expect_out(2, 0, 8, 6, 0, 3, 0);
      settle();
    end
    drive(K_E, 1'b0); expect_out(2, 1, 8, 6, 0, 3, 0, 1'b1, 5, 10); settle();
    drive(0, 1'b0);   expect_out(2, 1, 8, 6, 0, 3, 0); settle();
    drive(0, 1'b1);   expect_out(2, 1, 8, 6, 0, 2, 0); settle();
    drive(0, 1'b1);   expect_out(2, 1, 8, 6, 0, 1, 0); settle();
    drive(0, 1'b1);   expect_out(2, 3, 8, 6, 0, 0, 0); settle();
    drive(0, 1'b1);   expect_out(2, 3, 8, 6, 0, 0, 0); settle();
    drive(K_E, 1'b0); expect_out(2, 0, 8, 6, 0, 0, 0); settle();
    drive(0, 1'b0);   expect_out(2, 0, 8, 6, 0, 0, 0); settle();
    drive(K_E, 1'b0);
    t = rtg(m_a5, 8, 6);
    expect_out(2, 1, 8, 6, 0, 3, 0, 1'b1, int'(t[3:0]), int'(t[7:4]));
    settle();
    drive(0, 1'b0);   expect_out(2, 1, 8, 6, 0, 3, 0); settle();
    drive(K_U, 1'b1); expect_out(2, 1, 8, 5, 0, 2, 0); settle();
    drive(K_E, 1'b0); expect_out(2, 2, 8, 5, 0, 2, 0); settle();
    drive(0, 1'b0);   expect_out(2, 2, 8, 5, 0, 2, 0); settle();
    drive(K_X, 1'b0); expect_out(2, 0, 8, 6, 0, 3, 0); settle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
